// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus/check wrapper for a WIDTH-bit two-input AND gate: sweeps every
// (a,b) pair, samples c after SETTLE cycles, counts mismatches. Optional: GATE_SWEEP_ERRLOG_EN.
module gate_sweep_checker #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_SWEEP_ERRLOG_EN
  ,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_c
`endif
);

  localparam int IDX_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SETTLING, CHECK, FINISHED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mismatch;

`ifdef GATE_SWEEP_ERRLOG_EN
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
`endif

  // The operands are the index halves, so a/b come straight from a register.
  assign a         = idx_q[IDX_W-1:WIDTH];
  assign b         = idx_q[WIDTH-1:0];
  assign mismatch  = (c != (a & b));
  assign busy      = (state_q == SETTLING) || (state_q == CHECK);
  assign done      = (state_q == FINISHED);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

`ifdef GATE_SWEEP_ERRLOG_EN
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_c     = fc_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef GATE_SWEEP_ERRLOG_EN
    fv_d = fv_q;
    fa_d = fa_q;
    fb_d = fb_q;
    fc_d = fc_q;
`endif
    case (state_q)
      IDLE, FINISHED: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          state_d = SETTLING;
`ifdef GATE_SWEEP_ERRLOG_EN
          fv_d = 1'b0;
`endif
        end
      end
      SETTLING: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef GATE_SWEEP_ERRLOG_EN
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a;
            fb_d = b;
            fc_d = c;
          end
`endif
        end
        if (idx_q == LAST_IDX) begin
          state_d = FINISHED;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
`ifdef GATE_SWEEP_ERRLOG_EN
      fv_q <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
      fc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef GATE_SWEEP_ERRLOG_EN
      fv_q <= fv_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      fc_q <= fc_d;
`endif
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: directed runs with a bench-modelled gate on c,
// plus a second instance with ERR_W=4 and c tied low to exercise counter saturation.
module tb_gate_sweep_checker;

  localparam int RUN_LEN = 64 * 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] a, b, c;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [2:0] a2, b2;
  logic       busy2, done2, pass2;
  logic [3:0] err2;
`ifdef GATE_SWEEP_ERRLOG_EN
  logic       fail_valid, fv2;
  logic [2:0] fail_a, fail_b, fail_c, fa2, fb2, fc2;
`endif

  int mode  = 0;   // 0 AND, 1 stuck-at-0, 2 OR, 3 AND that is wrong outside the check cycle
  int phase = 0;
  int cyc   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         err;
    bit         pass;
    int         start_edge;
    bit         fv;
    logic [2:0] fa, fb, fc;
  } exp_t;
  exp_t sb[$];

  assign c = (mode == 1) ? 3'b000 :
             (mode == 2) ? (a | b) :
             (mode == 3 && phase != 2) ? ~(a & b) : (a & b);

  gate_sweep_checker #(.WIDTH(3), .SETTLE(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
`endif
  );

  gate_sweep_checker #(.WIDTH(3), .SETTLE(2), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .c(3'b000),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_c(fc2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: follows the sweep order while busy, pops the scoreboard when done rises.
  int         busy_cnt = 0;
  bit         done_q = 1'b0;
  logic [5:0] exp_idx;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      phase    = 0;
      done_q   = 1'b0;
    end else begin
      if (busy) begin
        exp_idx = 6'(busy_cnt / 3);
        check("sweep_a", a, exp_idx[5:3]);
        check("sweep_b", b, exp_idx[2:0]);
        phase = busy_cnt % 3;
        busy_cnt++;
      end else begin
        phase = 0;
      end
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("err_count", err_count, e.err);
          check("pass", pass, e.pass);
          check("busy_low", busy, 0);
          // done appears in the period following the edge N*(SETTLE+1) after the accepting edge
          check("done_latency", cyc - e.start_edge, RUN_LEN);
          check("busy_cycles", busy_cnt, RUN_LEN);
          check("last_a", a, 7);
          check("last_b", b, 7);
          check("sat_done", done2, 1);
          check("sat_err", err2, 15);
          check("sat_pass", pass2, 0);
`ifdef GATE_SWEEP_ERRLOG_EN
          check("fail_valid", fail_valid, e.fv);
          if (e.fv) begin
            check("fail_a", fail_a, e.fa);
            check("fail_b", fail_b, e.fb);
            check("fail_c", fail_c, e.fc);
          end
`endif
        end
        busy_cnt = 0;
      end
      done_q = done;
    end
  end

  task automatic run(input int m, input int exp_err, input bit extra_starts,
                     input bit fv, input logic [2:0] fa, input logic [2:0] fb, input logic [2:0] fc);
    exp_t x;
    mode = m;
    @(posedge clk); #1;
    start = 1'b1;
    x.err = exp_err; x.pass = (exp_err == 0); x.start_edge = cyc + 1;
    x.fv = fv; x.fa = fa; x.fb = fb; x.fc = fc;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
`ifdef GATE_SWEEP_ERRLOG_EN
    check("fail_valid_cleared", fail_valid, 0);
`endif
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
      start = extra_starts && (i % 40 == 20) && (i < 180);
    end
    start = 1'b0;
    check("run_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_hold_busy", busy, 0);

    run(0, 0,  1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    run(1, 37, 1'b0, 1'b1, 3'd1, 3'd1, 3'd0);
    run(2, 56, 1'b0, 1'b1, 3'd0, 3'd1, 3'd1);
    run(3, 0,  1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    run(0, 0,  1'b1, 1'b0, 3'd0, 3'd0, 3'd0);

    // Mid-run reset at vector 10 (a=1, b=2) with errors already counted
    mode = 1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !(a == 3'd1 && b == 3'd2); i++) begin
      @(posedge clk); #1;
    end
    check("reached_vec10", {a, b}, 6'd10);
    check("err_before_rst", err_count, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_a", a, 0);
    check("mid_rst_b", b, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_sat_err", err2, 0);
    rst_n = 1'b1;
    sb.delete();

    run(1, 37, 1'b0, 1'b1, 3'd1, 3'd1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
